tdm_demux4: RTL and testbench

- Receive end of the team's 4:1 select link: a serial time-division-multiplexed stream carries four channels in fixed slot order (d0, d1, d2, d3), and this block de-multiplexes it back to four parallel channel registers.
- Frame alignment comes from a frame-sync strobe.
- Output registers are double-buffered, so d0..d3 change atomically once per complete frame.
- Sits between the serial line/sampler and the consumer logic.

---
 rtl/tdm_demux4.sv | 128 ++++++++++++
 tb/tb_tdm_demux4.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM select link: frames a serial stream on fsync and
// hands the four channel words out together once per complete frame.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fsync,
  input  logic             din,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic             valid,
  output logic             locked,
  output logic [1:0]       slot,
  output logic             err
);

  // The frame position is kept as (slot, bit-in-slot) so that slot needs no divider.
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [1:0]    SLOT_ONE = (WIDTH == 1) ? 2'd1 : 2'd0;
  localparam logic [BW-1:0] BIT_ONE  = (WIDTH == 1) ? '0 : BW'(1);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             slot_q, slot_d, slot_inc;
  logic [BW-1:0]          bit_q, bit_d, bit_inc;
  logic [3:0][WIDTH-1:0]  sh_q, sh_d;
  logic [3:0][WIDTH-1:0]  dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   at_first, at_last;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
    logic [WIDTH:0] t;
    t = {w, b};
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    at_first = (slot_q == 2'd0) && (bit_q == '0);
    at_last  = (slot_q == 2'd3) && (bit_q == BIT_LAST);
    if (bit_q == BIT_LAST) begin
      bit_inc  = '0;
      slot_inc = slot_q + 2'd1;
    end else begin
      bit_inc  = bit_q + BW'(1);
      slot_inc = slot_q;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (fsync) begin
            sh_d[0] = shift_in(sh_q[0], din);
            slot_d  = SLOT_ONE;
            bit_d   = BIT_ONE;
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (fsync) begin
            // A misplaced fsync abandons the partial frame and restarts at bit 0.
            err_d   = !at_first;
            sh_d[0] = shift_in(sh_q[0], din);
            slot_d  = SLOT_ONE;
            bit_d   = BIT_ONE;
          end else if (at_first) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            sh_d[slot_q] = shift_in(sh_q[slot_q], din);
            slot_d       = slot_inc;
            bit_d        = bit_inc;
            if (at_last) begin
              dout_d  = sh_d;
              valid_d = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign d0     = dout_q[0];
  assign d1     = dout_q[1];
  assign d2     = dout_q[2];
  assign d3     = dout_q[3];
  assign valid  = valid_q;
  assign err    = err_q;
  assign locked = (state_q == LOCK);
  assign slot   = slot_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 at WIDTH=1 and WIDTH=4 with a frame scoreboard.
module tb_tdm_demux4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, en1, fs1, din1;
  logic a_d0, a_d1, a_d2, a_d3, a_valid, a_locked, a_err;
  logic [1:0] a_slot;

  logic rst4, en4, fs4, din4;
  logic [3:0] b_d0, b_d1, b_d2, b_d3;
  logic b_valid, b_locked, b_err;
  logic [1:0] b_slot;

  tdm_demux4 #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst1), .en(en1), .fsync(fs1), .din(din1),
    .d0(a_d0), .d1(a_d1), .d2(a_d2), .d3(a_d3),
    .valid(a_valid), .locked(a_locked), .slot(a_slot), .err(a_err)
  );

  tdm_demux4 #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst4), .en(en4), .fsync(fs4), .din(din4),
    .d0(b_d0), .d1(b_d1), .d2(b_d2), .d3(b_d3),
    .valid(b_valid), .locked(b_locked), .slot(b_slot), .err(b_err)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0]  q1[$];
  logic [15:0] q4[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest pending frame.
  always @(negedge clk) begin
    if (a_valid) begin
      chk("sb1_pending", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) chk("sb1_data", {a_d0, a_d1, a_d2, a_d3}, q1.pop_front());
    end
    if (b_valid) begin
      chk("sb4_pending", 32'(q4.size() > 0), 32'd1);
      if (q4.size() > 0) chk("sb4_data", {b_d0, b_d1, b_d2, b_d3}, q4.pop_front());
    end
  end

  task automatic step1(input string tag, input logic b, input logic fs, input logic e,
                       input logic [1:0] es, input logic el, input logic ev, input logic ee);
    din1 = b; fs1 = fs; en1 = e;
    @(posedge clk); #1;
    chk({tag, ".slot"}, a_slot, es);
    chk({tag, ".locked"}, a_locked, el);
    chk({tag, ".valid"}, a_valid, ev);
    chk({tag, ".err"}, a_err, ee);
  endtask

  task automatic step4(input string tag, input logic b, input logic fs, input logic e,
                       input logic [1:0] es, input logic el, input logic ev, input logic ee);
    din4 = b; fs4 = fs; en4 = e;
    @(posedge clk); #1;
    chk({tag, ".slot"}, b_slot, es);
    chk({tag, ".locked"}, b_locked, el);
    chk({tag, ".valid"}, b_valid, ev);
    chk({tag, ".err"}, b_err, ee);
  endtask

  // Sends the first nbits of a 16-bit frame MSB first; en=0 gap edges carry
  // fsync=1 and din=1 to show they are ignored.
  task automatic frame4(input string tag, input logic [15:0] word, input bit toggle,
                        input bit zero_chk, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      logic [1:0] es;
      es = 2'(((k + 1) % 16) / 4);
      if (k == 15) q4.push_back(word);
      step4(tag, word[15 - k], (k == 0), 1'b1, es, 1'b1, (k == 15), 1'b0);
      if (zero_chk && k < 15) chk({tag, ".hold0"}, {b_d0, b_d1, b_d2, b_d3}, 32'h0);
      if (toggle) step4({tag, ".gap"}, 1'b1, 1'b1, 1'b0, es, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst1 = 1'b1; en1 = 1'b0; fs1 = 1'b0; din1 = 1'b0;
    rst4 = 1'b1; en4 = 1'b0; fs4 = 1'b0; din4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst1.d", {a_d0, a_d1, a_d2, a_d3}, 32'h0);
    chk("rst1.locked", a_locked, 1'b0);
    chk("rst1.slot", a_slot, 2'd0);
    chk("rst1.valid", a_valid, 1'b0);
    chk("rst1.err", a_err, 1'b0);
    chk("rst4.d", {b_d0, b_d1, b_d2, b_d3}, 32'h0);
    chk("rst4.locked", b_locked, 1'b0);
    rst1 = 1'b0;
    rst4 = 1'b0;

    // WIDTH=1 basic frame 1,0,1,1
    step1("t1b0", 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    step1("t1b1", 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    step1("t1b2", 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    q1.push_back(4'b1011);
    step1("t1b3", 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    step1("t1post", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

    // fsync re-asserted at p=2
    step1("t4b0", 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    step1("t4b1", 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    step1("t4rs", 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
    chk("t4.hold", {a_d0, a_d1, a_d2, a_d3}, 32'hB);
    step1("t4r1", 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    step1("t4r2", 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    q1.push_back(4'b1100);
    step1("t4r3", 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);

    // fsync re-asserted at p=F-1: that frame is dropped
    step1("tlb0", 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    step1("tlb1", 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    step1("tlb2", 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    step1("tlrs", 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
    chk("tl.hold", {a_d0, a_d1, a_d2, a_d3}, 32'hC);
    step1("tlr1", 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    step1("tlr2", 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    q1.push_back(4'b1101);
    step1("tlr3", 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);

    // en=0 edge with fsync high changes nothing
    step1("tgap", 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

    // missing fsync at p=0 drops lock; later bits without fsync are ignored
    step1("t5miss", 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      step1("t5idle", 1'(i % 2), 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("t5.hold", {a_d0, a_d1, a_d2, a_d3}, 32'hD);

    // WIDTH=4 with en toggling, then back-to-back frames
    frame4("t2", 16'hA5C3, 1'b1, 1'b1, 16);
    frame4("t3a", 16'hA5C3, 1'b0, 1'b0, 16);
    frame4("t3b", 16'h0F96, 1'b0, 1'b0, 16);
    chk("t3.d", {b_d0, b_d1, b_d2, b_d3}, 32'h0F96);

    // reset mid-frame at p=3
    frame4("t6pre", 16'hFFFF, 1'b0, 1'b0, 3);
    rst4 = 1'b1;
    step4("t6rst", 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("t6.d", {b_d0, b_d1, b_d2, b_d3}, 32'h0);
    rst4 = 1'b0;
    frame4("t6", 16'h1234, 1'b0, 1'b1, 16);
    step4("t6post", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

    chk("sb1_drained", q1.size(), 32'd0);
    chk("sb4_drained", q4.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
